// File: rtl/mem32_resp.sv
// mem32_resp: multi-cycle MEM32 memory responder (fetch, byte/half/word load/store) with WAIT_CYCLES wait states.
// Build option: define MEM32_RESP_SEXT_EN to sign-extend sub-word loads (zero-extended otherwise).
module mem32_resp #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ,
    input  logic              WR,
    input  logic [1:0]        SIZE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       WDATA,
    output logic [31:0]       RDATA,
    output logic              ACK,
    output logic              ERR,
    output logic              BUSY
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int AW_USED = IDX_W + 2;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    function automatic logic access_err(input logic [1:0] size, input logic [1:0] lo);
        logic e;
        case (size)
            2'b00:   e = 1'b0;
            2'b01:   e = lo[0];
            2'b10:   e = (lo != 2'b00);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Selected lane is right-justified; extension mode is fixed at build time.
    function automatic logic [31:0] load_data(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
`ifdef MEM32_RESP_SEXT_EN
            2'b00:   r = {{24{b[7]}}, b};
            2'b01:   r = {{16{h[15]}}, h};
`else
            2'b00:   r = {24'h000000, b};
            2'b01:   r = {16'h0000, h};
`endif
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] old_word, input logic [31:0] wd,
                                                input logic [1:0] size, input logic [1:0] lo);
        logic [3:0]  be;
        logic [31:0] lane;
        logic [31:0] mask;
        be = byte_en(size, lo);
        case (size)
            2'b00:   lane = {4{wd[7:0]}};
            2'b01:   lane = {2{wd[15:0]}};
            default: lane = wd;
        endcase
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_word & ~mask) | (lane & mask);
    endfunction

    logic [1:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [1:0]         size_q, size_d;
    logic [AW_USED-1:0] addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    logic [31:0]        mem_q [DEPTH];

    logic               enter_resp_s;
    logic               acc_wr_s;
    logic [1:0]         acc_size_s;
    logic [AW_USED-1:0] acc_addr_s;
    logic               acc_err_s;
    logic [31:0]        rd_word_s;
    logic               mem_we_s;
    logic [IDX_W-1:0]   wr_idx_s;
    logic [31:0]        wr_word_s;
    logic               unused_addr_s;

    // Bits above the array span only alias and are intentionally dropped.
    assign unused_addr_s = ^ADDR[ADDR_W-1:AW_USED];

    // With zero wait states the access resolves on the acceptance edge, so read the live inputs then.
    assign acc_wr_s   = (state_q == S_IDLE) ? WR : wr_q;
    assign acc_size_s = (state_q == S_IDLE) ? SIZE : size_q;
    assign acc_addr_s = (state_q == S_IDLE) ? ADDR[AW_USED-1:0] : addr_q;
    assign acc_err_s  = access_err(acc_size_s, acc_addr_s[1:0]);
    assign rd_word_s  = mem_q[acc_addr_s[AW_USED-1:2]];
    assign wr_idx_s   = addr_q[AW_USED-1:2];
    assign wr_word_s  = merge_store(mem_q[wr_idx_s], wdata_q, size_q, addr_q[1:0]);

    // Next-state, request latch and response logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        enter_resp_s = 1'b0;
        mem_we_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    wr_d    = WR;
                    size_d  = SIZE;
                    addr_d  = ADDR[AW_USED-1:0];
                    wdata_d = WDATA;
                    if (WAIT_CYCLES == 0) begin
                        state_d      = S_RESP;
                        cnt_d        = 4'd0;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = S_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d  = S_IDLE;
                mem_we_s = wr_q && !access_err(size_q, addr_q[1:0]);
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (enter_resp_s) begin
            ack_d = 1'b1;
            err_d = acc_err_s;
            if (!acc_err_s && !acc_wr_s) begin
                rdata_d = load_data(rd_word_s, acc_size_s, acc_addr_s[1:0]);
            end else begin
                rdata_d = rdata_q;
            end
        end else begin
            rdata_d = rdata_q;
        end
        busy_d = (state_d != S_IDLE);
    end

    // Control and output registers; reset aborts any access in flight.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Word array, not reset; a store commits on the edge leaving RESP.
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_q[wr_idx_s] <= wr_word_s;
        end
    end

    assign RDATA = rdata_q;
    assign ACK   = ack_q;
    assign ERR   = err_q;
    assign BUSY  = busy_q;

endmodule
